instruction_fetch_unit: RTL and testbench

//   Producer side of the instruction stream that the control unit decodes.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 69 ++++++
 rtl/instruction_fetch_unit.sv | 75 +++++++
 tb/tb_instruction_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Definitions shared by the fetch and decode stages: instruction size,
// the canonical NOP encoding and the major opcodes.
package riscv_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    localparam logic [6:0] MEM_LOAD      = 7'b000_0011;
    localparam logic [6:0] MEM_STORE     = 7'b010_0011;
    localparam logic [6:0] R_TYPE        = 7'b011_0011;
    localparam logic [6:0] INT_IMMEDIATE = 7'b001_0011;
    localparam logic [6:0] BRANCH        = 7'b110_0011;
    localparam logic [6:0] JAL           = 7'b110_1111;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch unit's memory request/response channel, the
// downstream instruction handshake and the redirect input.
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  o_imem_req;
    logic                  i_imem_ready;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic                  i_imem_rvalid;
    logic [DATA_WIDTH-1:0] i_imem_rdata;
    logic                  o_instr_valid;
    logic                  i_instr_ready;
    logic [DATA_WIDTH-1:0] o_instr;
    logic [ADDR_WIDTH-1:0] o_instr_pc;
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;

    modport master (
        output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_ready,
               i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata, i_instr_ready,
               i_redirect, i_redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; the head entry is
// kept in its own register so downstream sees flop outputs.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0] count_q, remaining;
    logic [WIDTH-1:0] head_q, head_next;
    logic             head_en;

    // The new head is the next stored entry, or the incoming word when the
    // FIFO would otherwise be empty after this cycle's pop.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
        rd_next   = rd_ptr + PTR_W'(pop);
        remaining = count_q - CNT_W'(pop);
        head_en   = 1'b0;
        head_next = head_q;
        if (remaining == '0) begin
            head_en   = push;
            head_next = push_data;
        end else begin
            head_en   = pop;
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (head_en) head_q <= head_next;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: issues word reads under a credit limit, buffers in-order
// responses with their PCs and flushes on redirect.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic                      i_clk,
    input logic                      i_reset,
    instruction_fetch_unit_if.master bus
);

    localparam int                    CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [CNT_W:0]        CREDITS    = (CNT_W + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]            fetch_pc, resp_pc, redirect_pc;
    logic [CNT_W-1:0]                 in_flight, discard, fifo_count;
    logic                             credit_ok, accept, push, pop;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;

    assign redirect_pc = bus.i_redirect_pc & ALIGN_MASK;

    // Every outstanding request, stale or not, holds a slot it may land in.
    assign credit_ok = ((CNT_W + 1)'(in_flight) + (CNT_W + 1)'(fifo_count)) < CREDITS;

    assign bus.o_imem_req    = !i_reset && !bus.i_redirect && credit_ok;
    assign bus.o_imem_addr   = fetch_pc;
    assign accept            = bus.o_imem_req && bus.i_imem_ready;
    assign push              = bus.i_imem_rvalid && (discard == '0) && !bus.i_redirect;
    assign bus.o_instr_valid = fifo_count != '0;
    assign pop               = bus.o_instr_valid && bus.i_instr_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
        end else if (bus.i_redirect) begin
            // in_flight already counts responses marked for discard, so after
            // a redirect every outstanding response is stale.
            fetch_pc  <= redirect_pc;
            resp_pc   <= redirect_pc;
            in_flight <= in_flight - CNT_W'(bus.i_imem_rvalid);
            discard   <= in_flight - CNT_W'(bus.i_imem_rvalid);
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_STEP;
            if (push)   resp_pc  <= resp_pc + PC_STEP;
            in_flight <= in_flight + CNT_W'(accept) - CNT_W'(bus.i_imem_rvalid);
            if (bus.i_imem_rvalid && discard != '0) discard <= discard - CNT_W'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .flush     (bus.i_redirect),
        .push      (push),
        .push_data ({resp_pc, bus.i_imem_rdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign {bus.o_instr_pc, bus.o_instr} = fifo_head;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model with random latency
// and readiness, plus an expected-PC stream model of the decode side.
module tb_instruction_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1, ready_pct = 100;
    int          n_accept = 0;
    logic [31:0] exp_fetch_pc = RST_PC;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr;

    initial begin
        bus.i_imem_ready  = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            bus.i_imem_ready = ($urandom_range(99) < ready_pct);
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.i_imem_rvalid = 1'b1;
                bus.i_imem_rdata  = word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.i_imem_rvalid = 1'b0;
                bus.i_imem_rdata  = $urandom();
            end
            #2;
            if (rst) begin
                mq.delete();
                exp_fetch_pc = RST_PC;
                hold_pending = 1'b0;
            end else if (bus.i_redirect) begin
                check("req_low_on_redirect", bus.o_imem_req, 1'b0);
                exp_fetch_pc = bus.i_redirect_pc & ~32'h3;
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("req_held", bus.o_imem_req, 1'b1);
                    check("addr_held", bus.o_imem_addr, hold_addr);
                end
                hold_pending = 1'b0;
                if (bus.o_imem_req && bus.i_imem_ready) begin
                    check("fetch_addr", bus.o_imem_addr, exp_fetch_pc);
                    mq.push_back('{addr: bus.o_imem_addr,
                                   due: cyc + int'($urandom_range(lat_max, lat_min))});
                    acc_log.push_back(bus.o_imem_addr);
                    acc_cyc.push_back(cyc);
                    n_accept++;
                    exp_fetch_pc += 32'd4;
                end else if (bus.o_imem_req) begin
                    hold_pending = 1'b1;
                    hold_addr    = bus.o_imem_addr;
                end
            end
        end
    end

    // ---------------- decode-side model ----------------
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] last_pop_pc;
    bit          popped;
    int          n_pop = 0;

    task automatic observe_pop();
        popped = bus.o_instr_valid && bus.i_instr_ready;
        if (popped) begin
            last_pop_pc = bus.o_instr_pc;
            check("pop_pc", bus.o_instr_pc, exp_pc);
            check("pop_instr", bus.o_instr, word(exp_pc));
            exp_pc += 32'd4;
            n_pop++;
        end
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        bus.i_instr_ready = rdy;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        #1;
        observe_pop();
        if (redir) exp_pc = rpc & ~32'h3;
    endtask

    task automatic do_reset(input string tag);
        rst               = 1'b1;
        bus.i_instr_ready = 1'b0;
        bus.i_redirect    = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_req"},      bus.o_imem_req,    1'b0);
        check({tag, "_addr"},     bus.o_imem_addr,   RST_PC);
        check({tag, "_valid"},    bus.o_instr_valid, 1'b0);
        check({tag, "_instr"},    bus.o_instr,       32'h0);
        check({tag, "_instr_pc"}, bus.o_instr_pc,    32'h0);
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = RST_PC;
        acc_log.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] pc);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b1, 1'b0, 32'h0);
            got = popped;
        end
        check({tag, "_seen"}, got, 1'b1);
        if (got) check({tag, "_pc"}, last_pop_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n0, p0;
        rst               = 1'b1;
        bus.i_instr_ready = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        @(negedge clk);
        do_reset("reset");

        // Streaming with a 1-cycle memory.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
        check("stream_n_acc", acc_log.size() >= 3, 1'b1);
        if (acc_log.size() >= 3) begin
            check("stream_addr0", acc_log[0], 32'h0);
            check("stream_addr1", acc_log[1], 32'h4);
            check("stream_addr2", acc_log[2], 32'h8);
            check("stream_consec1", acc_cyc[1] - acc_cyc[0], 1);
            check("stream_consec2", acc_cyc[2] - acc_cyc[0], 2);
        end
        check("stream_pops", n_pop >= 3, 1'b1);

        // Back-pressure from decode for 10 cycles right after reset.
        @(negedge clk);
        do_reset("reset_bp");
        n0 = n_accept;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (bus.o_instr_valid) begin
                check("bp_hold_instr", bus.o_instr, word(32'h0));
                check("bp_hold_pc", bus.o_instr_pc, 32'h0);
            end
        end
        check("bp_valid", bus.o_instr_valid, 1'b1);
        check("bp_accepts", n_accept - n0, DEPTH);
        p0 = n_pop;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 32'h0);
        check("bp_drain", (n_pop - p0) >= DEPTH + 2, 1'b1);

        // Redirect to 0x100 with exactly two requests outstanding (3-cycle memory).
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            bus.i_instr_ready = 1'b1;
            bus.i_redirect    = (mq.size() == 2);
            bus.i_redirect_pc = 32'h100;
            #1;
            observe_pop();
            if (bus.i_redirect) begin
                found  = 1;
                exp_pc = 32'h100;
                check("redir1_req_low", bus.o_imem_req, 1'b0);
            end
        end
        check("redir1_found", found, 1'b1);
        step(1'b1, 1'b0, 32'h0);
        check("redir1_valid_cleared", bus.o_instr_valid, 1'b0);
        check("redir1_new_req", bus.o_imem_req, 1'b1);
        check("redir1_new_addr", bus.o_imem_addr, 32'h100);
        wait_pop("redir1_resume", 32'h100);

        // Redirect to 0x203 in a cycle with both a response and a pop.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            bus.i_instr_ready = 1'b1;
            bus.i_redirect    = 1'b0;
            #1;
            observe_pop();
            #2;
            if (bus.i_imem_rvalid && popped) begin
                bus.i_redirect    = 1'b1;
                bus.i_redirect_pc = 32'h203;
                exp_pc            = 32'h200;
                found             = 1;
            end
        end
        check("redir2_found", found, 1'b1);
        step(1'b1, 1'b0, 32'h0);
        check("redir2_valid_cleared", bus.o_instr_valid, 1'b0);
        check("redir2_new_addr", bus.o_imem_addr, 32'h200);
        wait_pop("redir2_resume", 32'h200);

        // Memory stalls with a request pending, then PC wraps past the top.
        ready_pct = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        acc_log.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0);
            check("stall_req", bus.o_imem_req, 1'b1);
            check("stall_addr", bus.o_imem_addr, 32'hFFFF_FFF8);
        end
        ready_pct = 100;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        check("wrap_n_acc", acc_log.size() >= 3, 1'b1);
        if (acc_log.size() >= 3) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            check("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            check("wrap_addr2", acc_log[2], 32'h0000_0000);
        end

        // Reset while requests are outstanding and the FIFO holds entries.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            bus.i_instr_ready = 1'b0;
            bus.i_redirect    = 1'b0;
            if (mq.size() == 2 && bus.o_instr_valid) found = 1;
        end
        check("midrst_found", found, 1'b1);
        do_reset("midrst");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        check("midrst_n_acc", acc_log.size() >= 1, 1'b1);
        if (acc_log.size() >= 1) check("midrst_restart_addr", acc_log[0], RST_PC);

        // Randomized traffic: random latency, readiness, decode stalls, redirects.
        lat_min = 1; lat_max = 4; ready_pct = 70;
        p0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(3) != 0, $urandom_range(59) == 0, $urandom());
        end
        check("rand_progress", (n_pop - p0) > 150, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
